// File: rtl/aes_result_checker.sv
// In-order expected-value scoreboard for the AES encoder/decoder pair.
// Each path has its own FIFO, so encoder and decoder latencies are independent.

module aes_rc_path #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_valid_i,
  input  logic [DATA_W-1:0] pop_data_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [DATA_W-1:0] head_o,
  output logic              miss_o,
  output logic              unexp_o,
  output logic [CNT_W-1:0]  pass_cnt_o,
  output logic [CNT_W-1:0]  fail_cnt_o,
  output logic              fail_pulse_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wptr_q, wptr_d;
  logic [AW:0]       rptr_q, rptr_d;
  logic [CNT_W-1:0]  pass_q, pass_d;
  logic [CNT_W-1:0]  fail_q, fail_d;
  logic              pulse_q, pulse_d;
  logic              pop;
  logic              hit;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign head_o  = mem_q[rptr_q[AW-1:0]];

  // An empty FIFO never pops: same-cycle push is not bypassed.
  assign pop     = pop_valid_i && !empty_o;
  assign miss_o  = pop && (head_o != pop_data_i);
  assign hit     = pop && (head_o == pop_data_i);
  assign unexp_o = pop_valid_i && empty_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    pulse_d = miss_o;
    if (push_i) wptr_d = wptr_q + PTR_ONE;
    if (pop)    rptr_d = rptr_q + PTR_ONE;
    if (hit && (pass_q != '1))
      pass_d = pass_q + CNT_ONE;
    if (miss_o && (fail_q != '1))
      fail_d = fail_q + CNT_ONE;
  end

  always_ff @(posedge clock) begin
    if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      pass_q  <= '0;
      fail_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      pulse_q <= pulse_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_i) mem_q[wptr_q[AW-1:0]] <= push_data_i;
  end

  assign pass_cnt_o   = pass_q;
  assign fail_cnt_o   = fail_q;
  assign fail_pulse_o = pulse_q;

endmodule

module aes_result_checker #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              exp_valid,
  output logic              exp_ready,
  input  logic [DATA_W-1:0] exp_cipher,
  input  logic [DATA_W-1:0] exp_plain,
  input  logic              enc_valid,
  input  logic [DATA_W-1:0] enc_data,
  input  logic              dec_valid,
  input  logic [DATA_W-1:0] dec_data,
  input  logic              clear,
  output logic [CNT_W-1:0]  enc_pass_cnt,
  output logic [CNT_W-1:0]  enc_fail_cnt,
  output logic [CNT_W-1:0]  dec_pass_cnt,
  output logic [CNT_W-1:0]  dec_fail_cnt,
  output logic [1:0]        fail_pulse,
  output logic              unexpected_err,
  output logic              first_fail_valid,
  output logic              first_fail_path,
  output logic [DATA_W-1:0] first_fail_got,
  output logic [DATA_W-1:0] first_fail_exp,
  output logic              idle
);

  logic              flush;
  logic              push;
  logic              enc_full, enc_empty, enc_miss, enc_unexp;
  logic              dec_full, dec_empty, dec_miss, dec_unexp;
  logic [DATA_W-1:0] enc_head, dec_head;
  logic              enc_pulse, dec_pulse;

  logic              unexp_q, unexp_d;
  logic              ffv_q, ffv_d;
  logic              ffp_q, ffp_d;
  logic [DATA_W-1:0] ffg_q, ffg_d;
  logic [DATA_W-1:0] ffe_q, ffe_d;

  assign flush     = reset || clear;
  assign exp_ready = !enc_full && !dec_full;
  assign push      = exp_valid && exp_ready;

  aes_rc_path #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) u_enc (
    .clock        (clock),
    .flush_i      (flush),
    .push_i       (push),
    .push_data_i  (exp_cipher),
    .pop_valid_i  (enc_valid),
    .pop_data_i   (enc_data),
    .full_o       (enc_full),
    .empty_o      (enc_empty),
    .head_o       (enc_head),
    .miss_o       (enc_miss),
    .unexp_o      (enc_unexp),
    .pass_cnt_o   (enc_pass_cnt),
    .fail_cnt_o   (enc_fail_cnt),
    .fail_pulse_o (enc_pulse)
  );

  aes_rc_path #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) u_dec (
    .clock        (clock),
    .flush_i      (flush),
    .push_i       (push),
    .push_data_i  (exp_plain),
    .pop_valid_i  (dec_valid),
    .pop_data_i   (dec_data),
    .full_o       (dec_full),
    .empty_o      (dec_empty),
    .head_o       (dec_head),
    .miss_o       (dec_miss),
    .unexp_o      (dec_unexp),
    .pass_cnt_o   (dec_pass_cnt),
    .fail_cnt_o   (dec_fail_cnt),
    .fail_pulse_o (dec_pulse)
  );

  // Encoder wins when both paths mismatch in the same cycle.
  always_comb begin
    unexp_d = unexp_q || enc_unexp || dec_unexp;
    ffv_d   = ffv_q;
    ffp_d   = ffp_q;
    ffg_d   = ffg_q;
    ffe_d   = ffe_q;
    if (!ffv_q && (enc_miss || dec_miss)) begin
      ffv_d = 1'b1;
      ffp_d = !enc_miss;
      ffg_d = enc_miss ? enc_data : dec_data;
      ffe_d = enc_miss ? enc_head : dec_head;
    end
  end

  always_ff @(posedge clock) begin
    if (flush) begin
      unexp_q <= 1'b0;
      ffv_q   <= 1'b0;
      ffp_q   <= 1'b0;
      ffg_q   <= '0;
      ffe_q   <= '0;
    end else begin
      unexp_q <= unexp_d;
      ffv_q   <= ffv_d;
      ffp_q   <= ffp_d;
      ffg_q   <= ffg_d;
      ffe_q   <= ffe_d;
    end
  end

  assign fail_pulse       = {dec_pulse, enc_pulse};
  assign unexpected_err   = unexp_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_path  = ffp_q;
  assign first_fail_got   = ffg_q;
  assign first_fail_exp   = ffe_q;
  assign idle             = enc_empty && dec_empty;

endmodule

// File: tb/tb_aes_result_checker.sv
// Randomized scoreboard bench for aes_result_checker.
// A queue-based reference model predicts every registered result.

module tb_aes_result_checker;

  localparam int DW    = 128;
  localparam int DEPTH = 16;
  localparam int CW    = 16;
  localparam int CMAX  = (1 << CW) - 1;

  localparam logic [DW-1:0] VC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [DW-1:0] VP = 128'h00112233445566778899aabbccddeeff;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          clear = 1'b0;
  logic          exp_valid = 1'b0;
  logic          exp_ready;
  logic [DW-1:0] exp_cipher = '0;
  logic [DW-1:0] exp_plain = '0;
  logic          enc_valid = 1'b0;
  logic [DW-1:0] enc_data = '0;
  logic          dec_valid = 1'b0;
  logic [DW-1:0] dec_data = '0;
  logic [CW-1:0] enc_pass_cnt, enc_fail_cnt;
  logic [CW-1:0] dec_pass_cnt, dec_fail_cnt;
  logic [1:0]    fail_pulse;
  logic          unexpected_err;
  logic          first_fail_valid;
  logic          first_fail_path;
  logic [DW-1:0] first_fail_got, first_fail_exp;
  logic          idle;

  aes_result_checker #(
    .DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .exp_valid        (exp_valid),
    .exp_ready        (exp_ready),
    .exp_cipher       (exp_cipher),
    .exp_plain        (exp_plain),
    .enc_valid        (enc_valid),
    .enc_data         (enc_data),
    .dec_valid        (dec_valid),
    .dec_data         (dec_data),
    .clear            (clear),
    .enc_pass_cnt     (enc_pass_cnt),
    .enc_fail_cnt     (enc_fail_cnt),
    .dec_pass_cnt     (dec_pass_cnt),
    .dec_fail_cnt     (dec_fail_cnt),
    .fail_pulse       (fail_pulse),
    .unexpected_err   (unexpected_err),
    .first_fail_valid (first_fail_valid),
    .first_fail_path  (first_fail_path),
    .first_fail_got   (first_fail_got),
    .first_fail_exp   (first_fail_exp),
    .idle             (idle)
  );

  always #5 clock = ~clock;

  typedef struct {
    int            ep, ef, dp, df;
    logic [1:0]    pulse;
    logic          unexp, ffv, ffp;
    logic [DW-1:0] ffg, ffe;
  } obs_t;

  logic [DW-1:0] meq[$];
  logic [DW-1:0] mdq[$];
  obs_t          sb_q[$];
  int            m_ep, m_ef, m_dp, m_df;
  logic          m_unexp, m_ffv, m_ffp;
  logic [DW-1:0] m_ffg, m_ffe;
  int            n_assert = 0;
  int            n_fail = 0;
  logic          mon_pend;

  function automatic void chk(string name, logic [DW-1:0] got,
                              logic [DW-1:0] want);
    n_assert++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
    end
  endfunction

  function automatic int sat(int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  function automatic void model_reset();
    meq.delete();
    mdq.delete();
    m_ep = 0; m_ef = 0; m_dp = 0; m_df = 0;
    m_unexp = 0; m_ffv = 0; m_ffp = 0;
    m_ffg = '0; m_ffe = '0;
  endfunction

  function automatic void chk_state();
    chk("exp_ready", exp_ready,
        (meq.size() < DEPTH) && (mdq.size() < DEPTH));
    chk("idle", idle, (meq.size() == 0) && (mdq.size() == 0));
    chk("enc_pass_cnt", enc_pass_cnt, m_ep);
    chk("enc_fail_cnt", enc_fail_cnt, m_ef);
    chk("dec_pass_cnt", dec_pass_cnt, m_dp);
    chk("dec_fail_cnt", dec_fail_cnt, m_df);
    chk("unexpected_err", unexpected_err, m_unexp);
    chk("first_fail_valid", first_fail_valid, m_ffv);
    chk("first_fail_path", first_fail_path, m_ffp);
    chk("first_fail_got", first_fail_got, m_ffg);
    chk("first_fail_exp", first_fail_exp, m_ffe);
  endfunction

  // One clock of stimulus; the model advances to the post-edge state.
  task automatic cycle(input logic pv, input logic [DW-1:0] pc,
                       input logic [DW-1:0] pp, input logic ev,
                       input logic [DW-1:0] ed, input logic dv,
                       input logic [DW-1:0] dd, input logic rs,
                       input logic cl);
    logic          rdy, pe, pd;
    logic [DW-1:0] h;
    obs_t          o;
    @(negedge clock);
    if (!reset && !clear) chk_state();
    exp_valid = pv; exp_cipher = pc; exp_plain = pp;
    enc_valid = ev; enc_data = ed;
    dec_valid = dv; dec_data = dd;
    reset = rs; clear = cl;
    if (rs || cl) begin
      model_reset();
    end else begin
      rdy = (meq.size() < DEPTH) && (mdq.size() < DEPTH);
      pe = 0; pd = 0;
      if (ev) begin
        if (meq.size() == 0) m_unexp = 1;
        else begin
          h = meq.pop_front();
          if (h == ed) m_ep = sat(m_ep + 1);
          else begin m_ef = sat(m_ef + 1); pe = 1; end
          if (pe && !m_ffv) begin
            m_ffv = 1; m_ffp = 0; m_ffg = ed; m_ffe = h;
          end
        end
      end
      if (dv) begin
        if (mdq.size() == 0) m_unexp = 1;
        else begin
          h = mdq.pop_front();
          if (h == dd) m_dp = sat(m_dp + 1);
          else begin m_df = sat(m_df + 1); pd = 1; end
          if (pd && !m_ffv) begin
            m_ffv = 1; m_ffp = 1; m_ffg = dd; m_ffe = h;
          end
        end
      end
      if (pv && rdy) begin
        meq.push_back(pc);
        mdq.push_back(pp);
      end
      if (ev || dv) begin
        o.ep = m_ep; o.ef = m_ef; o.dp = m_dp; o.df = m_df;
        o.pulse = {pd, pe}; o.unexp = m_unexp;
        o.ffv = m_ffv; o.ffp = m_ffp; o.ffg = m_ffg; o.ffe = m_ffe;
        sb_q.push_back(o);
      end
    end
  endtask

  task automatic nop(input int n);
    repeat (n) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic push(input logic [DW-1:0] c, input logic [DW-1:0] p);
    cycle(1, c, p, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic enc(input logic [DW-1:0] d);
    cycle(0, 0, 0, 1, d, 0, 0, 0, 0);
  endtask

  task automatic dec(input logic [DW-1:0] d);
    cycle(0, 0, 0, 0, 0, 1, d, 0, 0);
  endtask

  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor: every result-bearing cycle pops one prediction.
  initial begin
    obs_t o;
    forever begin
      @(posedge clock);
      mon_pend = (enc_valid || dec_valid) && !reset && !clear;
      #1;
      if (mon_pend) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          o = sb_q.pop_front();
          chk("mon_enc_pass", enc_pass_cnt, o.ep);
          chk("mon_enc_fail", enc_fail_cnt, o.ef);
          chk("mon_dec_pass", dec_pass_cnt, o.dp);
          chk("mon_dec_fail", dec_fail_cnt, o.df);
          chk("mon_fail_pulse", fail_pulse, o.pulse);
          chk("mon_unexp", unexpected_err, o.unexp);
          chk("mon_ff_valid", first_fail_valid, o.ffv);
          chk("mon_ff_path", first_fail_path, o.ffp);
          chk("mon_ff_got", first_fail_got, o.ffg);
          chk("mon_ff_exp", first_fail_exp, o.ffe);
        end
      end else begin
        chk("quiet_fail_pulse", fail_pulse, 2'b00);
      end
    end
  end

  logic [DW-1:0] cv[17];
  logic [DW-1:0] pv_[17];

  initial begin
    logic          rp, re, rd;
    logic [DW-1:0] ed, dd;
    int            guard;
    model_reset();
    // Reset for three cycles, then check the idle state.
    repeat (3) cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
    nop(2);

    // Matching pair with different encoder/decoder latencies.
    push(VC, VP);
    nop(4);
    enc(VC);
    nop(3);
    dec(VP);
    nop(2);

    // Encoder mismatch, then a second one that must not move the capture.
    push(VC, VP);
    push(VC, VP);
    enc(VC ^ 128'h1);
    enc(128'h1234);
    dec(VP);
    cycle(0, 0, 0, 0, 0, 1, VP ^ 128'h80, 0, 0);
    nop(2);

    // Fill to capacity, hold the 17th offer, then drain in order.
    for (int i = 0; i < 17; i++) begin
      cv[i] = rnd128();
      pv_[i] = rnd128();
    end
    for (int i = 0; i < 16; i++) push(cv[i], pv_[i]);
    push(cv[16], pv_[16]);
    push(cv[16], pv_[16]);
    cycle(1, cv[16], pv_[16], 1, cv[0], 1, pv_[0], 0, 0);
    push(cv[16], pv_[16]);
    for (int i = 1; i < 17; i++)
      cycle(0, 0, 0, 1, cv[i], 1, pv_[i], 0, 0);
    nop(2);

    // Pop with nothing queued, then soft clear.
    enc(rnd128());
    dec(rnd128());
    nop(1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
    nop(2);

    // Reset mid-operation discards queued expectations.
    for (int i = 0; i < 5; i++) push(rnd128(), rnd128());
    enc(meq[0]);
    dec(mdq[0]);
    enc(meq[0]);
    dec(mdq[0]);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
    nop(2);
    enc(rnd128());
    nop(2);

    // Random traffic with ~20% corrupted results and rare clears.
    for (int n = 0; n < 600; n++) begin
      rp = ($urandom_range(0, 1) == 1);
      re = ($urandom_range(0, 2) == 0);
      rd = ($urandom_range(0, 2) == 0);
      ed = (meq.size() > 0 && $urandom_range(0, 4) != 0) ? meq[0] : rnd128();
      dd = (mdq.size() > 0 && $urandom_range(0, 4) != 0) ? mdq[0] : rnd128();
      if ($urandom_range(0, 199) == 0)
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
      else
        cycle(rp, rnd128(), rnd128(), re, ed, rd, dd, 0, 0);
    end
    guard = 0;
    while ((meq.size() > 0 || mdq.size() > 0) && guard < 64) begin
      cycle(0, 0, 0, meq.size() > 0, (meq.size() > 0) ? meq[0] : '0,
            mdq.size() > 0, (mdq.size() > 0) ? mdq[0] : '0, 0, 0);
      guard++;
    end
    chk("drain_bound", guard < 64, 1);
    nop(3);
    chk("scoreboard_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
